// File: rtl/paillier_pkg.sv
// Shared types and constants for the Paillier modular arithmetic datapath.
package paillier_pkg;

  localparam int unsigned MM_WIDTH = 32;
  // The extra two bits hold 2P + R < 3n without overflow.
  localparam int unsigned MM_ACC_W = MM_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    MULT   = 2'd2,
    FINISH = 2'd3
  } mm_state_e;

endpackage

// File: rtl/mod_dbl_add_step.sv
// One interleaved step: (2*acc + addend) followed by up to two conditional subtractions of n.
module mod_dbl_add_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH+1:0] acc,
  input  logic [WIDTH+1:0] addend,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH+1:0] sum
);

  localparam int unsigned ACC_W = WIDTH + 2;

  logic [ACC_W-1:0] nx;
  logic [ACC_W-1:0] s0;
  logic [ACC_W-1:0] s1;

  always_comb begin
    nx  = ACC_W'(n);
    s0  = (acc << 1) + addend;
    s1  = (s0 >= nx) ? (s0 - nx) : s0;
    sum = (s1 >= nx) ? (s1 - nx) : s1;
  end

endmodule

// File: rtl/mod_mult_interleaved.sv
// Bit-serial interleaved modular multiplier: result = (a * b) mod n.
// Optional macro MODMUL_SKIP_REDUCE_EN bypasses the REDUCE pass when a < n.
module mod_mult_interleaved
  import paillier_pkg::*;
#(
  parameter int unsigned WIDTH = MM_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             valid
);

  localparam int unsigned ACC_W = WIDTH + 2;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mm_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] a_q, a_nxt, b_q, b_nxt, n_q, n_nxt;
  logic [ACC_W-1:0] r, r_nxt, p, p_nxt;
  logic             busy_nxt, done_nxt, valid_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic [ACC_W-1:0] red_sum, mult_sum;

  mod_dbl_add_step #(.WIDTH(WIDTH)) u_red_step (
    .acc    (r),
    .addend (ACC_W'(a_q[cnt])),
    .n      (n_q),
    .sum    (red_sum)
  );

  mod_dbl_add_step #(.WIDTH(WIDTH)) u_mult_step (
    .acc    (p),
    .addend (b_q[cnt] ? r : '0),
    .n      (n_q),
    .sum    (mult_sum)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (n == '0) state_nxt = FINISH;
`ifdef MODMUL_SKIP_REDUCE_EN
          else if (a < n) state_nxt = MULT;
`endif
          else state_nxt = REDUCE;
        end
      end
      REDUCE:  if (cnt == '0) state_nxt = MULT;
      MULT:    if (cnt == '0) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_nxt    = cnt;
    a_nxt      = a_q;
    b_nxt      = b_q;
    n_nxt      = n_q;
    r_nxt      = r;
    p_nxt      = p;
    busy_nxt   = busy;
    done_nxt   = done;
    valid_nxt  = valid;
    result_nxt = result;
    case (state)
      IDLE: begin
        if (start) begin
          a_nxt      = a;
          b_nxt      = b;
          n_nxt      = n;
          r_nxt      = '0;
          p_nxt      = '0;
          cnt_nxt    = CNT_W'(WIDTH - 1);
          busy_nxt   = 1'b1;
          done_nxt   = 1'b0;
          valid_nxt  = 1'b0;
          result_nxt = '0;
`ifdef MODMUL_SKIP_REDUCE_EN
          if ((n != '0) && (a < n)) r_nxt = ACC_W'(a);
`endif
        end
      end
      REDUCE: begin
        r_nxt = red_sum;
        if (cnt == '0) begin
          cnt_nxt = CNT_W'(WIDTH - 1);
          p_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      MULT: begin
        p_nxt = mult_sum;
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
      end
      FINISH: begin
        result_nxt = (n_q != '0) ? p[WIDTH-1:0] : '0;
        valid_nxt  = (n_q != '0);
        done_nxt   = 1'b1;
        busy_nxt   = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      r      <= '0;
      p      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      valid  <= 1'b0;
      result <= '0;
    end else begin
      cnt    <= cnt_nxt;
      a_q    <= a_nxt;
      b_q    <= b_nxt;
      n_q    <= n_nxt;
      r      <= r_nxt;
      p      <= p_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      valid  <= valid_nxt;
      result <= result_nxt;
    end
  end

endmodule

// File: tb/tb_mod_mult_interleaved.sv
// Directed bench for mod_mult_interleaved (WIDTH=32); honours MODMUL_SKIP_REDUCE_EN for latency.
module tb_mod_mult_interleaved;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b, n;
  logic        busy, done, valid;
  logic [31:0] result;

  int nvec = 0;
  int nerr = 0;
  int lat;

  mod_mult_interleaved #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .result (result),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept a start at edge 0, then count edges until done rises (bounded).
  task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] nv);
    @(negedge clk);
    a = av; b = bv; n = nv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
  endtask

  task automatic wait_done();
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] nv, input logic [31:0] exp_r, input logic exp_v,
                     input int exp_lat);
    launch(av, bv, nv);
    chk({tag, "_busy_on"}, 32'(busy), 32'd1);
    wait_done();
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, result, exp_r);
    chk({tag, "_valid"}, 32'(valid), 32'(exp_v));
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; n = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run("basic", 32'd7, 32'd3, 32'd11, 32'd10, 1'b1, 65);
    chk("basic_done_held", 32'(done), 32'd1);
    run("a_ge_n", 32'd25, 32'd4, 32'd11, 32'd1, 1'b1, 65);
`ifdef MODMUL_SKIP_REDUCE_EN
    run("a_lt_n", 32'd3, 32'd4, 32'd11, 32'd1, 1'b1, 33);
`else
    run("a_lt_n", 32'd3, 32'd4, 32'd11, 32'd1, 1'b1, 65);
`endif
    run("maxw", 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 1'b1, 65);
    run("n_zero", 32'd5, 32'd6, 32'd0, 32'd0, 1'b0, 1);
    run("n_one", 32'd9, 32'd9, 32'd1, 32'd0, 1'b1, 65);
    run("a_zero", 32'd0, 32'd5, 32'd11, 32'd0, 1'b1, 65);
    run("b_zero", 32'd6, 32'd0, 32'd11, 32'd0, 1'b1, 65);
    run("paillier", 32'd7, 32'd13, 32'd15, 32'd1, 1'b1, 65);

    // A second start mid-operation with different operands is ignored.
    launch(32'd7, 32'd3, 32'd11);
    chk("ign_done_cleared", 32'(done), 32'd0);
    repeat (9) @(posedge clk);
    #1; lat += 9;
    @(negedge clk);
    a = 32'd2; start = 1'b1;
    @(posedge clk);
    #1; lat++;
    start = 1'b0;
    wait_done();
    chk("ign_latency", 32'(lat), 32'd65);
    chk("ign_result", result, 32'd10);

    // Reset mid-operation aborts at once.
    launch(32'd7, 32'd3, 32'd11);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run("after_rst", 32'd2, 32'd5, 32'd7, 32'd3, 1'b1, 65);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
